// File: rtl/cdec_ctrl_seq.sv
// cdec_ctrl_seq: multi-cycle fetch/decode/execute sequencer for the CDEC CPU.
// Fetches opcode/operand bytes over a req/ready port and drives ALU controls.
// Ports: clk, reset_n (async, active low), run (start pulse in IDLE),
//   mem_req/mem_we/mem_ready/mem_rdata (memory handshake), addr_sel,
//   pc_inc/pc_load (PC strobes), ir/opnd (latched bytes), aluop/alu_bsel,
//   rega_we/regb_we/ld_sel (register writes), szcy_in/flags/cy_to_alu,
//   halted, step_mode/step (single-step; active only with CDEC_CTRL_STEP_EN).
// Optional macro: CDEC_CTRL_STEP_EN enables single-step gating of FETCH.
module cdec_ctrl_seq #(
  parameter bit AUTO_RUN = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       run,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       pc_inc,
  output logic       pc_load,
  output logic [7:0] ir,
  output logic [7:0] opnd,
  output logic [3:0] aluop,
  output logic       alu_bsel,
  output logic       rega_we,
  output logic       regb_we,
  output logic       ld_sel,
  input  logic [2:0] szcy_in,
  output logic [2:0] flags,
  output logic       cy_to_alu,
  output logic       halted,
  input  logic       step_mode,
  input  logic       step
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_FETCH_OP,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [7:0] ir_q;
  logic [7:0] opnd_q;
  logic [2:0] flags_q;
  logic [3:0] aluop_q;

  logic is_alu;
  logic is_imm;
  logic is_jmp;
  logic is_ld;
  logic is_st;
  logic jmp_ok;
  logic rd_two;
  logic rd_halt;
  logic fetch_go;
  logic fetch_done;
  logic op_done;

  // Decode of the latched instruction
  assign is_alu = ~ir_q[7];
  assign is_imm = is_alu & ir_q[1];
  assign is_jmp = (ir_q[7:4] == 4'b1000);
  assign is_ld  = (ir_q == 8'hC0);
  assign is_st  = (ir_q == 8'hD0);

  // Decode of the byte arriving in FETCH, to pick the next state
  assign rd_halt = (mem_rdata == 8'hFF);
  assign rd_two  = (~mem_rdata[7] & mem_rdata[1])
                 | (mem_rdata[7:4] == 4'b1000)
                 | (mem_rdata == 8'hC0)
                 | (mem_rdata == 8'hD0);

  // flags = {S, Z, Cy}
  always_comb begin
    jmp_ok = 1'b0;
    case (ir_q[3:0])
      4'h0:    jmp_ok = 1'b1;
      4'h1:    jmp_ok = flags_q[1];
      4'h2:    jmp_ok = ~flags_q[1];
      4'h3:    jmp_ok = flags_q[0];
      4'h4:    jmp_ok = ~flags_q[0];
      4'h5:    jmp_ok = flags_q[2];
      4'h6:    jmp_ok = ~flags_q[2];
      default: jmp_ok = 1'b0;
    endcase
  end

`ifdef CDEC_CTRL_STEP_EN
  // A step seen while waiting in FETCH arms exactly one opcode fetch;
  // steps during the rest of the instruction fall through unseen.
  logic step_ok_q;

  assign fetch_go = ~step_mode | step_ok_q | step;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step_ok_q <= 1'b0;
    end else if (fetch_done) begin
      step_ok_q <= 1'b0;
    end else if (state_q == S_FETCH && step) begin
      step_ok_q <= 1'b1;
    end
  end
`else
  logic unused_step;

  assign unused_step = step_mode ^ step;
  assign fetch_go    = 1'b1;
`endif

  assign fetch_done = (state_q == S_FETCH) & fetch_go & mem_ready;
  assign op_done    = (state_q == S_FETCH_OP) & mem_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (run || AUTO_RUN) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (fetch_done) begin
          unique case (1'b1)
            rd_halt: state_d = S_HALT;
            rd_two:  state_d = S_FETCH_OP;
            default: state_d = S_EXEC;
          endcase
        end
      end
      S_FETCH_OP: begin
        if (mem_ready) state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = (is_ld | is_st) ? S_MEM : S_FETCH;
      end
      S_MEM: begin
        if (mem_ready) state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    addr_sel = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    aluop    = aluop_q;
    alu_bsel = 1'b0;
    rega_we  = 1'b0;
    regb_we  = 1'b0;
    ld_sel   = 1'b0;
    halted   = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = fetch_go;
        pc_inc  = fetch_done;
      end
      S_FETCH_OP: begin
        mem_req = 1'b1;
        pc_inc  = mem_ready;
      end
      S_EXEC: begin
        if (is_alu) begin
          aluop    = ir_q[6:3];
          alu_bsel = is_imm;
          rega_we  = ~ir_q[2];
          regb_we  = ir_q[2];
        end
        pc_load = is_jmp & jmp_ok;
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = is_st;
        rega_we  = is_ld & mem_ready;
        ld_sel   = is_ld & mem_ready;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        halted = 1'b0;
      end
    endcase
  end

  // aluop_q keeps the last issued opcode so aluop is stable between ops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_q    <= '0;
      opnd_q  <= '0;
      flags_q <= '0;
      aluop_q <= '0;
    end else begin
      if (fetch_done) ir_q <= mem_rdata;
      if (op_done) opnd_q <= mem_rdata;
      if (state_q == S_EXEC && is_alu) begin
        flags_q <= szcy_in;
        aluop_q <= ir_q[6:3];
      end
    end
  end

  assign ir        = ir_q;
  assign opnd      = opnd_q;
  assign flags     = flags_q;
  assign cy_to_alu = flags_q[0];

endmodule

// File: tb/tb_cdec_ctrl_seq.sv
// tb_cdec_ctrl_seq: directed literal checks plus random programs checked
// cycle by cycle against an instruction-level model of the sequencer.
`timescale 1ns/1ps
module tb_cdec_ctrl_seq;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       run;
  logic [7:0] mem_rdata;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       addr_sel;
  logic       pc_inc;
  logic       pc_load;
  logic [7:0] ir;
  logic [7:0] opnd;
  logic [3:0] aluop;
  logic       alu_bsel;
  logic       rega_we;
  logic       regb_we;
  logic       ld_sel;
  logic [2:0] szcy_in;
  logic [2:0] flags;
  logic       cy_to_alu;
  logic       halted;
  logic       step_mode;
  logic       step;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cdec_ctrl_seq #(.AUTO_RUN(1'b0)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .run       (run),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .addr_sel  (addr_sel),
    .pc_inc    (pc_inc),
    .pc_load   (pc_load),
    .ir        (ir),
    .opnd      (opnd),
    .aluop     (aluop),
    .alu_bsel  (alu_bsel),
    .rega_we   (rega_we),
    .regb_we   (regb_we),
    .ld_sel    (ld_sel),
    .szcy_in   (szcy_in),
    .flags     (flags),
    .cy_to_alu (cy_to_alu),
    .halted    (halted),
    .step_mode (step_mode),
    .step      (step)
  );

  // kind: 0 = memory access, 1 = execute cycle, 2 = halted forever
  // cap:  0 = opcode byte, 1 = operand byte, 2 = data access
  typedef struct {
    int         kind;
    logic [7:0] addr;
    bit         asel;
    bit         we;
    bit         ld;
    int         cap;
    bit         alu;
    logic [3:0] op;
    bit         bsel;
    bit         wa;
    bit         wb;
    bit         pl;
  } item_t;

  item_t      q[$];
  logic [7:0] mem [256];
  logic [7:0] m_pc;
  logic [7:0] m_ir;
  logic [7:0] m_opnd;
  logic [2:0] m_fl;
  logic [3:0] m_op;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, got, want, $time);
    end
  endtask

  task automatic drive(input logic r, input logic [7:0] d,
                       input logic [2:0] s);
    mem_ready = r;
    mem_rdata = d;
    szcy_in   = s;
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // reset, then a run pulse; returns one tick after the edge entering FETCH
  task automatic start();
    reset_n = 1'b0;
    run     = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    run     = 1'b1;
    drive(1'b0, 8'h00, 3'b000);
    adv();
    run = 1'b0;
  endtask

  function automatic item_t mk(int k, logic [7:0] a, bit as, bit w,
                               bit l, int cp);
    item_t it;
    it.kind = k;
    it.addr = a;
    it.asel = as;
    it.we   = w;
    it.ld   = l;
    it.cap  = cp;
    it.alu  = 1'b0;
    it.op   = 4'h0;
    it.bsel = 1'b0;
    it.wa   = 1'b0;
    it.wb   = 1'b0;
    it.pl   = 1'b0;
    return it;
  endfunction

  function automatic logic [7:0] gen();
    int r;
    logic [7:0] v;
    r = int'($urandom % 100);
    v = 8'($urandom);
    if (r < 45) return {1'b0, v[6:0]};
    if (r < 60) return {4'h8, v[3:0]};
    if (r < 68) return 8'hC0;
    if (r < 76) return 8'hD0;
    if (r < 78) return 8'hFF;
    return v;
  endfunction

  // Expand the instruction at m_pc into its expected bus/exec cycles
  task automatic expand();
    logic [7:0] b;
    logic [7:0] t;
    bit isalu;
    bit isjmp;
    bit isld;
    bit isst;
    bit two;
    bit tk;
    item_t it;
    b     = mem[m_pc];
    t     = mem[m_pc + 8'd1];
    isalu = !b[7];
    isjmp = (b[7:4] == 4'h8);
    isld  = (b == 8'hC0);
    isst  = (b == 8'hD0);
    two   = (isalu && b[1]) || isjmp || isld || isst;
    case (b[3:0])
      4'h0:    tk = 1'b1;
      4'h1:    tk = m_fl[1];
      4'h2:    tk = !m_fl[1];
      4'h3:    tk = m_fl[0];
      4'h4:    tk = !m_fl[0];
      4'h5:    tk = m_fl[2];
      4'h6:    tk = !m_fl[2];
      default: tk = 1'b0;
    endcase
    q.push_back(mk(0, m_pc, 1'b0, 1'b0, 1'b0, 0));
    if (b == 8'hFF) begin
      q.push_back(mk(2, 8'h00, 1'b0, 1'b0, 1'b0, 2));
      return;
    end
    if (two) q.push_back(mk(0, m_pc + 8'd1, 1'b0, 1'b0, 1'b0, 1));
    it      = mk(1, 8'h00, 1'b0, 1'b0, 1'b0, 2);
    it.alu  = isalu;
    it.op   = b[6:3];
    it.bsel = isalu && b[1];
    it.wa   = isalu && !b[2];
    it.wb   = isalu && b[2];
    it.pl   = isjmp && tk;
    q.push_back(it);
    if (isld || isst) q.push_back(mk(0, t, 1'b1, isst, isld, 2));
    if (isjmp && tk) m_pc = t;
    else m_pc = m_pc + (two ? 8'd2 : 8'd1);
  endtask

  initial begin
    reset_n   = 1'b0;
    run       = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = 8'h00;
    szcy_in   = 3'b000;
    step_mode = 1'b0;
    step      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {mem_req, halted}, 2'b00);
    chk("rst_regs", {ir, opnd, flags, aluop}, 23'h0);
    chk("rst_strb", {mem_we, addr_sel, pc_inc, pc_load, alu_bsel,
                     rega_we, regb_we, ld_sel}, 8'h00);
    reset_n = 1'b1;
    drive(1'b1, 8'h28, 3'b111);
    chk("idle_noreq", {mem_req, pc_inc, ir}, 10'h0);
    adv();
    run = 1'b1;
    drive(1'b0, 8'h00, 3'b000);
    adv();
    run = 1'b0;

    // ALU 0101 -> A, register operand
    drive(1'b1, 8'h28, 3'b000);
    chk("fetch1", {mem_req, addr_sel, mem_we, pc_inc}, 4'b1001);
    adv();
    drive(1'b0, 8'h00, 3'b010);
    chk("exec1", {aluop, rega_we, regb_we, alu_bsel}, 7'b0101_100);
    adv();
    // ALU 1010 -> B, immediate 0F
    drive(1'b1, 8'h56, 3'b000);
    chk("flags1", {flags, ir}, {3'b010, 8'h28});
    adv();
    drive(1'b1, 8'h0F, 3'b000);
    chk("fetch_op", {mem_req, pc_inc, aluop}, 6'b11_0101);
    adv();
    drive(1'b0, 8'h00, 3'b001);
    chk("exec_imm", {opnd, aluop, alu_bsel, regb_we, rega_we},
        {8'h0F, 4'b1010, 3'b110});
    adv();
    drive(1'b1, 8'h28, 3'b000);
    chk("flags2", {flags, cy_to_alu}, 4'b0011);
    adv();
    drive(1'b0, 8'h00, 3'b010);
    adv();
    // jump if Z, Z set
    drive(1'b1, 8'h81, 3'b000);
    adv();
    drive(1'b1, 8'h40, 3'b000);
    adv();
    drive(1'b0, 8'h00, 3'b111);
    chk("jz_taken", {pc_load, flags}, 4'b1010);
    adv();
    drive(1'b1, 8'h28, 3'b000);
    chk("jmp_keep", flags, 3'b010);
    adv();
    drive(1'b0, 8'h00, 3'b000);
    adv();
    // jump if Z, Z clear
    drive(1'b1, 8'h81, 3'b000);
    adv();
    drive(1'b1, 8'h40, 3'b000);
    adv();
    drive(1'b0, 8'h00, 3'b000);
    chk("jz_not", pc_load, 1'b0);
    adv();
    drive(1'b1, 8'h28, 3'b000);
    adv();
    drive(1'b0, 8'h00, 3'b111);
    adv();
    // condition 1111 never taken, even with every flag set
    drive(1'b1, 8'h8F, 3'b000);
    adv();
    drive(1'b1, 8'h40, 3'b000);
    adv();
    drive(1'b0, 8'h00, 3'b000);
    chk("j_never", {pc_load, flags}, 4'b0111);
    adv();
    drive(1'b1, 8'h80, 3'b000);
    adv();
    drive(1'b1, 8'h12, 3'b000);
    adv();
    drive(1'b0, 8'h00, 3'b000);
    chk("j_always", pc_load, 1'b1);
    adv();
    // LD A,[80] with three wait cycles
    drive(1'b1, 8'hC0, 3'b000);
    adv();
    drive(1'b1, 8'h80, 3'b000);
    adv();
    drive(1'b1, 8'h55, 3'b000);
    chk("ld_exec", {mem_req, rega_we, pc_load}, 3'b000);
    adv();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'hAA, 3'b000);
      chk("ld_wait", {mem_req, addr_sel, mem_we, rega_we, ld_sel, pc_inc},
          6'b110000);
      adv();
    end
    drive(1'b1, 8'h99, 3'b000);
    chk("ld_done", {mem_req, addr_sel, rega_we, ld_sel, pc_inc, flags},
        8'b11110_111);
    adv();
    drive(1'b0, 8'h00, 3'b000);
    chk("ld_after", {mem_req, addr_sel, rega_we, ld_sel, flags},
        7'b1000_111);
    adv();
    // ST [33],A
    drive(1'b1, 8'hD0, 3'b000);
    adv();
    drive(1'b1, 8'h33, 3'b000);
    adv();
    drive(1'b0, 8'h00, 3'b000);
    adv();
    drive(1'b1, 8'h00, 3'b000);
    chk("st_mem", {mem_req, addr_sel, mem_we, rega_we, ld_sel}, 5'b11100);
    adv();
    // HALT
    drive(1'b1, 8'hFF, 3'b000);
    adv();
    for (int i = 0; i < 20; i++) begin
      drive(1'($urandom), 8'($urandom), 3'($urandom));
      chk("halt", {mem_req, halted, pc_inc}, 3'b010);
      adv();
    end
    // asynchronous reset while a fetch is pending
    start();
    drive(1'b1, 8'h28, 3'b000);
    adv();
    drive(1'b0, 8'h00, 3'b101);
    adv();
    drive(1'b0, 8'h00, 3'b000);
    chk("pre_rst", {mem_req, ir, flags}, {1'b1, 8'h28, 3'b101});
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst", {mem_req, ir, flags}, 12'h0);
    @(posedge clk);
    #1;

`ifdef CDEC_CTRL_STEP_EN
    step_mode = 1'b1;
    start();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'h56, 3'b000);
      chk("step_wait", {mem_req, pc_inc}, 2'b00);
      adv();
    end
    step = 1'b1;
    drive(1'b1, 8'h56, 3'b000);
    chk("step_go", {mem_req, pc_inc}, 2'b11);
    adv();
    drive(1'b1, 8'h0F, 3'b000);
    chk("step_op", {mem_req, pc_inc}, 2'b11);
    adv();
    step = 1'b0;
    drive(1'b0, 8'h00, 3'b100);
    chk("step_exec", {regb_we, alu_bsel}, 2'b11);
    adv();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'h28, 3'b000);
      chk("step_hold", {mem_req, pc_inc}, 2'b00);
      adv();
    end
    step_mode = 1'b0;
`else
    step_mode = 1'b1;
    step      = 1'b0;
    start();
    drive(1'b1, 8'h28, 3'b000);
    chk("step_ignored", {mem_req, pc_inc}, 2'b11);
    adv();
    step_mode = 1'b0;
`endif

    // random programs against the instruction-level model
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 256; i++) mem[i] = gen();
      q.delete();
      m_pc   = 8'h00;
      m_fl   = 3'b000;
      m_op   = 4'h0;
      m_ir   = 8'h00;
      m_opnd = 8'h00;
      start();
      for (int c = 0; c < 300; c++) begin
        item_t      hd;
        logic       rdy;
        logic [7:0] d;
        logic [33:0] got;
        logic [33:0] want;
        logic e_req, e_we, e_as, e_inc, e_pl, e_bs, e_wa, e_wb, e_ld, e_h;
        logic [3:0] e_op;
        if (q.size() == 0) expand();
        hd  = q[0];
        rdy = (($urandom % 100) < 60);
        d   = (rdy && hd.kind == 0) ? mem[hd.addr] : 8'($urandom);
`ifdef CDEC_CTRL_STEP_EN
        step_mode = 1'b0;
        step      = 1'($urandom);
`else
        step_mode = 1'($urandom);
        step      = 1'($urandom);
`endif
        drive(rdy, d, 3'($urandom));
        {e_req, e_we, e_as, e_inc, e_pl, e_bs, e_wa, e_wb, e_ld, e_h} = '0;
        e_op = m_op;
        case (hd.kind)
          0: begin
            e_req = 1'b1;
            e_as  = hd.asel;
            e_we  = hd.we;
            e_inc = rdy && hd.cap != 2;
            e_wa  = rdy && hd.ld;
            e_ld  = rdy && hd.ld;
          end
          1: begin
            if (hd.alu) begin
              e_op = hd.op;
              e_bs = hd.bsel;
              e_wa = hd.wa;
              e_wb = hd.wb;
            end
            e_pl = hd.pl;
          end
          default: e_h = 1'b1;
        endcase
        want = {e_req, e_we, e_as, e_inc, e_pl, e_op, e_bs, e_wa, e_wb,
                e_ld, m_fl, m_fl[0], e_h, m_ir, m_opnd};
        got  = {mem_req, mem_we, addr_sel, pc_inc, pc_load, aluop, alu_bsel,
                rega_we, regb_we, ld_sel, flags, cy_to_alu, halted, ir, opnd};
        chk("cycle", got, want);
        if (hd.kind == 0 && rdy) begin
          if (hd.cap == 0) m_ir = d;
          if (hd.cap == 1) m_opnd = d;
          void'(q.pop_front());
        end else if (hd.kind == 1) begin
          if (hd.alu) begin
            m_fl = szcy_in;
            m_op = hd.op;
          end
          void'(q.pop_front());
        end
        adv();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
